// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 streaming convolution: coefficient width,
// kernel geometry, raster tap indices and the accumulator width rule.
package conv_pkg;
  localparam int COEF_W = 8;
  localparam int KSIZE  = 3;
  localparam int NTAPS  = 9;

  localparam int TAP_TL     = 0;
  localparam int TAP_TC     = 1;
  localparam int TAP_TR     = 2;
  localparam int TAP_ML     = 3;
  localparam int TAP_CENTER = 4;
  localparam int TAP_MR     = 5;
  localparam int TAP_BL     = 6;
  localparam int TAP_BC     = 7;
  localparam int TAP_BR     = 8;

  // Unsigned sample times signed coef needs dw+COEF_W+1 bits; nine terms add 4 more.
  function automatic int acc_width(input int dw);
    return dw + COEF_W + 5;
  endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// One video line of storage: single shared address, asynchronous read of the
// old contents while the new sample is written at the clock edge.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr] <= wdata;
  end
endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over CH parallel channels with programmable signed taps.
// Define CONV_SATURATE_EN to clamp results to [0, 2^DW-1]; otherwise the low DW bits wrap.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int CH    = 3,
  parameter int DW    = 8,
  parameter int SHIFT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CH*DW-1:0]  din,
  input  logic              din_valid,
  input  logic              din_sof,
  input  logic              coef_wr,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [CH*DW-1:0]  dout,
  output logic              dout_valid,
  output logic              dout_sof
);
  localparam int ACC_W = acc_width(DW);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = 12;
  localparam int PW    = CH * DW;

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic          frm_act_q, frm_act_d;
  logic          sof_acc;
  logic          vld_p0_q, vld_p0_d, sof_p0_q, sof_p0_d;
  logic          dout_valid_q, dout_sof_q;
  logic [PW-1:0] dout_q, dout_d;
  logic [PW-1:0] lb0_rd, lb1_rd;
  logic [PW-1:0] win_q [KSIZE][KSIZE];
  logic [PW-1:0] win_d [KSIZE][KSIZE];
  logic signed [COEF_W-1:0] coef_q [NTAPS];
  logic signed [COEF_W-1:0] coef_d [NTAPS];
  logic signed [ACC_W-1:0]  acc_d    [CH];
  logic signed [ACC_W-1:0]  acc_p0_q [CH];

  function automatic logic [DW-1:0] shape(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> SHIFT;
`ifdef CONV_SATURATE_EN
    if (sh < 0) return '0;
    if (sh > $signed({{(ACC_W-DW){1'b0}}, {DW{1'b1}}})) return '1;
`endif
    return sh[DW-1:0];
  endfunction

  // lb0 holds row r-1, lb1 holds row r-2; lb1 is fed from lb0's outgoing sample
  conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW), .AW(CW)) u_lb0 (
    .clk(clk), .wr_en(din_valid), .addr(col_eff), .wdata(din), .rdata(lb0_rd)
  );
  conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW), .AW(CW)) u_lb1 (
    .clk(clk), .wr_en(din_valid), .addr(col_eff), .wdata(lb0_rd), .rdata(lb1_rd)
  );

  always_comb begin
    sof_acc   = din_valid && din_sof;
    col_eff   = sof_acc ? '0 : col_q;
    row_eff   = sof_acc ? '0 : row_q;
    col_d     = col_q;
    row_d     = row_q;
    frm_act_d = frm_act_q || sof_acc;
    if (din_valid) begin
      if (col_eff == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_eff == '1) ? row_eff : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
    end
    // Output only once this frame has filled two lines and three columns
    vld_p0_d = din_valid && frm_act_d && (row_eff >= RW'(2)) && (col_eff >= CW'(2));
    sof_p0_d = vld_p0_d && (row_eff == RW'(2)) && (col_eff == CW'(2));
  end

  always_comb begin
    for (int t = 0; t < NTAPS; t++) begin
      coef_d[t] = coef_q[t];
      if (coef_wr && coef_addr == 4'(t)) coef_d[t] = $signed(coef_data);
    end
  end

  always_comb begin
    for (int kr = 0; kr < KSIZE; kr++)
      for (int kc = 0; kc < KSIZE; kc++)
        win_d[kr][kc] = win_q[kr][kc];
    if (din_valid) begin
      for (int kr = 0; kr < KSIZE; kr++) begin
        win_d[kr][0] = win_q[kr][1];
        win_d[kr][1] = win_q[kr][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = din;
    end
  end

  always_comb begin : mac
    logic signed [ACC_W-1:0] sum, sx, cx;
    for (int ch = 0; ch < CH; ch++) begin
      sum = '0;
      for (int kr = 0; kr < KSIZE; kr++) begin
        for (int kc = 0; kc < KSIZE; kc++) begin
          sx  = {{(ACC_W-DW){1'b0}}, win_d[kr][kc][ch*DW +: DW]};
          cx  = {{(ACC_W-COEF_W){coef_q[kr*KSIZE+kc][COEF_W-1]}}, coef_q[kr*KSIZE+kc]};
          sum = sum + sx * cx;
        end
      end
      acc_d[ch] = sum;
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (vld_p0_q) begin
      for (int ch = 0; ch < CH; ch++) dout_d[ch*DW +: DW] = shape(acc_p0_q[ch]);
    end
  end

  // Stage p0: counters, coefficients, window and accumulators
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q     <= '0;
      row_q     <= '0;
      frm_act_q <= 1'b0;
      vld_p0_q  <= 1'b0;
      sof_p0_q  <= 1'b0;
      for (int t = 0; t < NTAPS; t++)
        coef_q[t] <= (t == TAP_CENTER) ? COEF_W'(1 << SHIFT) : '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      frm_act_q <= frm_act_d;
      vld_p0_q  <= vld_p0_d;
      sof_p0_q  <= sof_p0_d;
      for (int t = 0; t < NTAPS; t++) coef_q[t] <= coef_d[t];
    end
  end

  always_ff @(posedge clk) begin
    for (int kr = 0; kr < KSIZE; kr++)
      for (int kc = 0; kc < KSIZE; kc++)
        win_q[kr][kc] <= win_d[kr][kc];
    if (din_valid) begin
      for (int ch = 0; ch < CH; ch++) acc_p0_q[ch] <= acc_d[ch];
    end
  end

  // Stage p1: shift, clamp or wrap, and present
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_sof_q   <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= vld_p0_q;
      dout_sof_q   <= sof_p0_q;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_sof   = dout_sof_q;
endmodule
